// File: rtl/unix_time_pkg.sv
// Shared state type and timekeeping constants for the unix-time to BCD clock converter.
package unix_time_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DAY,
    S_HOUR,
    S_MIN,
    S_BCD
  } state_t;

  localparam logic [17:0] SEC_PER_DAY  = 18'd86400;
  localparam logic [17:0] SEC_PER_HOUR = 18'd3600;
  localparam logic [17:0] SEC_PER_MIN  = 18'd60;
  localparam logic [3:0]  BLANK_DIGIT  = 4'hF;

endpackage

// File: rtl/bin2bcd6.sv
// Combinational 6-bit binary (0..59) to two BCD digits; values above 59 show blank digits.
module bin2bcd6
  import unix_time_pkg::*;
(
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] offs;

  always_comb begin
    tens = 4'd0;
    offs = 6'd0;
    if (bin >= 6'd50) begin
      tens = 4'd5;
      offs = 6'd50;
    end else if (bin >= 6'd40) begin
      tens = 4'd4;
      offs = 6'd40;
    end else if (bin >= 6'd30) begin
      tens = 4'd3;
      offs = 6'd30;
    end else if (bin >= 6'd20) begin
      tens = 4'd2;
      offs = 6'd20;
    end else if (bin >= 6'd10) begin
      tens = 4'd1;
      offs = 6'd10;
    end
    ones = 4'(bin - offs);
    if (bin > 6'd59) begin
      tens = BLANK_DIGIT;
      ones = BLANK_DIGIT;
    end
  end

endmodule

// File: rtl/unix_time_bcd.sv
// Converts a unix seconds counter (plus a timezone offset) into BCD hh:mm:ss using
// a bit-serial restoring divider: 64 steps mod-day, 17 steps per hour, 12 per minute, 1 BCD cycle.
module unix_time_bcd
  import unix_time_pkg::*;
#(
  parameter longint signed TZ_OFFSET_SEC = 28800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] counter,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  min_bcd,
  output logic [7:0]  sec_bcd,
  output logic        busy,
  output logic        done
);

  localparam logic [63:0] TZ_ADD = 64'(TZ_OFFSET_SEC);

  state_t      state, state_nxt;
  logic [63:0] last_cnt;
  logic        captured;
  logic        start;
  logic [63:0] dvd, dvd_next;
  logic [16:0] rem, rem_next;
  logic [17:0] rem_shift, divisor;
  logic        qbit;
  logic [6:0]  step;
  logic        last_step;
  logic [4:0]  hours;
  logic [5:0]  minutes, seconds;
  logic [3:0]  h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;

  assign start = (state == S_IDLE) && (!captured || counter != last_cnt);
  assign busy  = (state != S_IDLE);

  // One restoring-division step; quotient bits shift into the low end of dvd.
  always_comb begin
    divisor   = SEC_PER_DAY;
    last_step = 1'b0;
    case (state)
      S_DAY: begin
        divisor   = SEC_PER_DAY;
        last_step = (step == 7'd63);
      end
      S_HOUR: begin
        divisor   = SEC_PER_HOUR;
        last_step = (step == 7'd16);
      end
      S_MIN: begin
        divisor   = SEC_PER_MIN;
        last_step = (step == 7'd11);
      end
      default: ;
    endcase
    rem_shift = {rem, dvd[63]};
    qbit      = (rem_shift >= divisor);
    rem_next  = qbit ? 17'(rem_shift - divisor) : rem_shift[16:0];
    dvd_next  = {dvd[62:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DAY;
      S_DAY:   if (last_step) state_nxt = S_HOUR;
      S_HOUR:  if (last_step) state_nxt = S_MIN;
      S_MIN:   if (last_step) state_nxt = S_BCD;
      S_BCD:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cnt <= '0;
      captured <= 1'b0;
      dvd      <= '0;
      rem      <= '0;
      step     <= '0;
      hours    <= '0;
      minutes  <= '0;
      seconds  <= '0;
      hour_bcd <= 8'h00;
      min_bcd  <= 8'h00;
      sec_bcd  <= 8'h00;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd      <= counter + TZ_ADD;
            rem      <= '0;
            step     <= '0;
            last_cnt <= counter;
            captured <= 1'b1;
          end
        end
        S_DAY, S_HOUR, S_MIN: begin
          step <= last_step ? 7'd0 : step + 7'd1;
          if (!last_step) begin
            dvd <= dvd_next;
            rem <= rem_next;
          end else if (state == S_DAY) begin
            dvd <= {rem_next, 47'd0};
            rem <= '0;
          end else if (state == S_HOUR) begin
            hours <= dvd_next[4:0];
            dvd   <= {rem_next[11:0], 52'd0};
            rem   <= '0;
          end else begin
            minutes <= dvd_next[5:0];
            seconds <= rem_next[5:0];
          end
        end
        S_BCD: begin
          hour_bcd <= {h_tens, h_ones};
          min_bcd  <= {m_tens, m_ones};
          sec_bcd  <= {s_tens, s_ones};
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  bin2bcd6 u_hour (.bin({1'b0, hours}), .tens(h_tens), .ones(h_ones));
  bin2bcd6 u_min  (.bin(minutes),       .tens(m_tens), .ones(m_ones));
  bin2bcd6 u_sec  (.bin(seconds),       .tens(s_tens), .ones(s_ones));

endmodule

// File: tb/tb_unix_time_bcd.sv
// Directed bench for unix_time_bcd: expected hh:mm:ss queued on stimulus, popped on each done pulse.
module tb_unix_time_bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] counter;
  logic [7:0]  hour_bcd, min_bcd, sec_bcd;
  logic        busy, done;

  int total = 0;
  int bad   = 0;
  logic [23:0] sb[$];

  int r_ndone, r_first, r_last, r_busy, r_gap;

  unix_time_bcd #(.TZ_OFFSET_SEC(28800)) dut (
    .clk      (clk),
    .reset    (reset),
    .counter  (counter),
    .hour_bcd (hour_bcd),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model(input logic [63:0] c);
    logic [63:0] t, s;
    int h, m, x;
    t = c + 64'd28800;
    s = t % 64'd86400;
    h = int'(s / 64'd3600);
    m = int'((s % 64'd3600) / 64'd60);
    x = int'(s % 64'd60);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  // Runs ncyc cycles sampled on the falling edge; n==1 is the first rising edge of the run.
  task automatic run(input string tag, input int ncyc, input int chg_at, input logic [63:0] chg_val);
    logic [23:0] prev, exp;
    int hold_bad;
    r_ndone = 0; r_first = -1; r_last = -1; r_busy = 0; r_gap = 0; hold_bad = 0;
    prev = {hour_bcd, min_bcd, sec_bcd};
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == chg_at) counter = chg_val;
      if (busy) begin
        r_busy++;
        if ({hour_bcd, min_bcd, sec_bcd} !== prev) hold_bad++;
      end
      if (done) begin
        r_ndone++;
        if (r_first < 0) r_first = n;
        r_last = n;
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          chk({tag, "_time"}, 64'({hour_bcd, min_bcd, sec_bcd}), 64'(exp));
        end
      end else if (r_ndone == 0 && !busy) begin
        r_gap++;
      end
      prev = {hour_bcd, min_bcd, sec_bcd};
    end
    chk({tag, "_hold_while_busy"}, 64'(hold_bad), 64'd0);
  endtask

  task automatic single(input string tag, input logic [63:0] c, input logic [23:0] exp);
    counter = c;
    sb.push_back(exp);
    run(tag, 100, 0, 64'd0);
    chk({tag, "_ndone"}, 64'(r_ndone), 64'd1);
    chk({tag, "_latency"}, 64'(r_first), 64'd95);
    chk({tag, "_busy_cycles"}, 64'(r_busy), 64'd94);
    chk({tag, "_busy_gap"}, 64'(r_gap), 64'd0);
  endtask

  initial begin
    reset   = 1'b1;
    counter = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hour", 64'(hour_bcd), 64'h00);
    chk("rst_min",  64'(min_bcd),  64'h00);
    chk("rst_sec",  64'(sec_bcd),  64'h00);
    chk("rst_busy", 64'(busy),     64'd0);
    chk("rst_done", 64'(done),     64'd0);
    reset = 1'b0;

    single("first", 64'd0, 24'h080000);
    single("eod",   64'd57599, 24'h235959);
    single("wrap",  64'd57600, 24'h000000);
    single("date",  64'd1725000000, 24'h144000);
    single("ovf",   64'hFFFF_FFFF_FFFF_FFFF, 24'h075959);
    single("misc",  64'd987654321, model(64'd987654321));

    counter = 64'd100;
    sb.push_back(24'h080140);
    sb.push_back(24'h080320);
    run("race", 250, 10, 64'd200);
    chk("race_ndone", 64'(r_ndone), 64'd2);
    chk("race_first", 64'(r_first), 64'd95);
    chk("race_second", 64'(r_last), 64'd190);
    chk("race_busy_cycles", 64'(r_busy), 64'd188);

    counter = 64'd5000;
    run("abort", 40, 0, 64'd0);
    chk("abort_ndone", 64'(r_ndone), 64'd0);
    chk("abort_busy_cycles", 64'(r_busy), 64'd40);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_hour", 64'(hour_bcd), 64'h00);
    chk("abort_min",  64'(min_bcd),  64'h00);
    chk("abort_sec",  64'(sec_bcd),  64'h00);
    chk("abort_busy", 64'(busy),     64'd0);
    chk("abort_done", 64'(done),     64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    single("post_rst", 64'd5000, model(64'd5000));

    run("idle", 1000, 0, 64'd0);
    chk("idle_ndone", 64'(r_ndone), 64'd0);
    chk("idle_busy_cycles", 64'(r_busy), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
